// File: rtl/reaction_ctrl.sv
// reaction_ctrl: game sequencer for the DE10-Lite reaction timer.
// Owns the game FSM, pseudo-random start delay, BCD reaction counter,
// score capture and high-score register, and drives the display fields.
module reaction_ctrl #(
    parameter int          DELAY_MIN_MS    = 1000,
    parameter int          DELAY_SPAN_BITS = 12,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       MAX10_CLK1_50,
    input  logic       rst_n,
    input  logic       tick_1k,
    input  logic [1:0] key_n,
    input  logic       buffs_sw,
    output logic [2:0] state,
    output logic       go_led,
    output logic [3:0] disp_s,
    output logic [3:0] disp_ds,
    output logic [3:0] disp_cs,
    output logic       disp_blank,
    output logic       hi_new,
    output logic       false_start
);

    localparam logic [2:0] HI_SCORE   = 3'b000;
    localparam logic [2:0] DELAYING   = 3'b001;
    localparam logic [2:0] TIMING     = 3'b010;
    localparam logic [2:0] DISPLAYING = 3'b011;
    localparam logic [2:0] GO_BUFFS   = 3'b100;

    localparam logic [11:0] SCORE_MAX = 12'h999;
    localparam logic [15:0] CNT_MAX   = 16'h9999;

    // Key synchronizer and press detection
    logic [1:0] key_s1, key_s2, key_q;
    logic [1:0] press;

    // Keys are two-flop synchronized; key_q holds the previous synced level.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            key_q  <= 2'b11;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            key_q  <= key_s2;
        end
    end

    // Active-low keys: a press is a high-to-low transition.
    assign press = key_q & ~key_s2;

    // LFSR
    logic [15:0] lfsr;

    // Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Datapath state
    logic [15:0] delay_cnt, nxt_delay;
    logic [15:0] cnt, nxt_cnt, cnt_inc;       // {s, ds, cs, ms} BCD
    logic [11:0] score, nxt_score;
    logic [11:0] hi_score, nxt_hi;
    logic [2:0]  nxt_state;
    logic        nxt_hn, nxt_fs;
    logic        capture;
    logic [11:0] cap_val;
    logic [11:0] nxt_disp;
    logic        nxt_blank;
    logic [15:0] delay_load;

    assign delay_load = 16'(DELAY_MIN_MS) + 16'(lfsr[DELAY_SPAN_BITS-1:0]);

    // Four-digit BCD increment with per-digit 9->0 carry.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign cnt_inc = bcd_inc(cnt);

    // Next-state and next-data logic; buffs_sw overrides every other event.
    always_comb begin
        nxt_state = state;
        nxt_delay = delay_cnt;
        nxt_cnt   = cnt;
        nxt_score = score;
        nxt_hi    = hi_score;
        nxt_hn    = hi_new;
        nxt_fs    = false_start;
        capture   = 1'b0;
        cap_val   = cnt[15:4];

        if (buffs_sw) begin
            nxt_state = GO_BUFFS;
        end else begin
            case (state)
                HI_SCORE: begin
                    if (press[0]) begin
                        nxt_state = DELAYING;
                        nxt_delay = delay_load;
                        nxt_fs    = 1'b0;
                        nxt_hn    = 1'b0;
                    end
                end
                DELAYING: begin
                    // An early start press wins over expiry in the same cycle.
                    if (press[0]) begin
                        nxt_state = HI_SCORE;
                        nxt_fs    = 1'b1;
                    end else if (press[1]) begin
                        nxt_state = HI_SCORE;
                    end else if (tick_1k) begin
                        if (delay_cnt == 16'd1) begin
                            nxt_state = TIMING;
                            nxt_cnt   = 16'h0000;
                        end
                        if (delay_cnt != 16'd0) nxt_delay = delay_cnt - 16'd1;
                    end
                end
                TIMING: begin
                    // A stop press alongside a tick captures the pre-increment value.
                    if (press[0]) begin
                        capture = 1'b1;
                        cap_val = cnt[15:4];
                    end else if (tick_1k && cnt != CNT_MAX) begin
                        nxt_cnt = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            capture = 1'b1;
                            cap_val = SCORE_MAX;
                        end
                    end
                end
                DISPLAYING: begin
                    if (press[1]) begin
                        nxt_state = HI_SCORE;
                    end else if (press[0]) begin
                        nxt_state = DELAYING;
                        nxt_delay = delay_load;
                        nxt_fs    = 1'b0;
                        nxt_hn    = 1'b0;
                    end
                end
                GO_BUFFS: begin
                    nxt_state = HI_SCORE;
                end
                default: begin
                    nxt_state = HI_SCORE;
                end
            endcase

            if (capture) begin
                nxt_state = DISPLAYING;
                nxt_score = cap_val;
                if (cap_val < hi_score) begin
                    nxt_hi = cap_val;
                    nxt_hn = 1'b1;
                end
            end
        end
    end

    // Display selection from the next state so outputs are valid on entry.
    always_comb begin
        nxt_disp  = 12'h000;
        nxt_blank = 1'b0;
        case (nxt_state)
            HI_SCORE:   nxt_disp = nxt_hi;
            DELAYING:   nxt_blank = 1'b1;
            TIMING:     nxt_disp = nxt_cnt[15:4];
            DISPLAYING: nxt_disp = nxt_score;
            default:    nxt_blank = 1'b1;
        endcase
    end

    // Register FSM, datapath and outputs together.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HI_SCORE;
            delay_cnt   <= 16'd0;
            cnt         <= 16'h0000;
            score       <= SCORE_MAX;
            hi_score    <= SCORE_MAX;
            hi_new      <= 1'b0;
            false_start <= 1'b0;
            go_led      <= 1'b0;
            disp_s      <= 4'd9;
            disp_ds     <= 4'd9;
            disp_cs     <= 4'd9;
            disp_blank  <= 1'b0;
        end else begin
            state       <= nxt_state;
            delay_cnt   <= nxt_delay;
            cnt         <= nxt_cnt;
            score       <= nxt_score;
            hi_score    <= nxt_hi;
            hi_new      <= nxt_hn;
            false_start <= nxt_fs;
            go_led      <= (nxt_state == TIMING);
            disp_s      <= nxt_disp[11:8];
            disp_ds     <= nxt_disp[7:4];
            disp_cs     <= nxt_disp[3:0];
            disp_blank  <= nxt_blank;
        end
    end

endmodule
